// File: rtl/mesh_unloader.sv
// -----------------------------------------------------------------------------
// mesh_unloader
//
// Drains one accumulated output mesh from the adder tree. A whole mesh of
// MESH_X*MESH_Y signed OUT_BIT words is captured in one cycle. It is then
// streamed one element per cycle over a valid/ready interface. On the way out,
// each element is arithmetically shifted right by SHIFT and saturated to Q_BIT.
// A second (pending) buffer lets the next mesh be captured while the current
// one is still streaming.
//
// States:
//   state    | meaning
//   ---------+---------------------------------------------------------------
//   S_IDLE   | active buffer empty, nothing presented on the stream
//   S_STREAM | active buffer holds a mesh, element idx_q is on m_data
//
// Ports:
//   clk         clock, rising edge
//   rst         synchronous reset, active-high
//   ena         capture enable (gates capture only, never the stream)
//   load_valid  data_in holds a complete mesh
//   load_ready  a capture is possible this cycle (ena & ~pend_full)
//   data_in     input mesh, element i at [(i+1)*OUT_BIT-1 : i*OUT_BIT]
//   m_valid     stream word valid
//   m_ready     downstream accepts the word
//   m_data      shifted, saturated element
//   m_last_row  word is the last element of a row
//   m_last      word is the last element of the mesh
//   busy        active or pending buffer occupied
// -----------------------------------------------------------------------------
module mesh_unloader #(
    parameter int OUT_BIT = 32,
    parameter int MESH_X  = 8,
    parameter int MESH_Y  = 8,
    parameter int Q_BIT   = 16,
    parameter int SHIFT   = 0
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               ena,
    input  logic                               load_valid,
    output logic                               load_ready,
    input  logic [MESH_X*MESH_Y*OUT_BIT-1:0]   data_in,
    output logic                               m_valid,
    input  logic                               m_ready,
    output logic [Q_BIT-1:0]                   m_data,
    output logic                               m_last_row,
    output logic                               m_last,
    output logic                               busy
);

    localparam int N      = MESH_X * MESH_Y;
    localparam int MESH_W = N * OUT_BIT;
    localparam int IDX_W  = (N > 1) ? $clog2(N) : 1;
    localparam int COL_W  = (MESH_X > 1) ? $clog2(MESH_X) : 1;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(MESH_X - 1);

    // Saturation bounds expressed at the input width so the comparison is a
    // plain signed compare against the shifted element.
    localparam logic signed [OUT_BIT-1:0] Q_MAX =
        {{(OUT_BIT - Q_BIT + 1){1'b0}}, {(Q_BIT - 1){1'b1}}};
    localparam logic signed [OUT_BIT-1:0] Q_MIN = ~Q_MAX;

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_STREAM = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [MESH_W-1:0]  act_q, act_d;
    logic [MESH_W-1:0]  pend_q, pend_d;
    logic               pend_full_q, pend_full_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [COL_W-1:0]   col_q, col_d;

    logic               m_valid_q, m_valid_d;
    logic [Q_BIT-1:0]   m_data_q, m_data_d;
    logic               m_last_row_q, m_last_row_d;
    logic               m_last_q, m_last_d;

    logic               capture;
    logic               beat;
    logic               last_beat;
    logic [OUT_BIT-1:0] elem_sel;

    function automatic logic [Q_BIT-1:0] quantize(input logic [OUT_BIT-1:0] elem);
        logic signed [OUT_BIT-1:0] v;
        v = $signed(elem) >>> SHIFT;
        if (v > Q_MAX) begin
            return Q_MAX[Q_BIT-1:0];
        end else if (v < Q_MIN) begin
            return Q_MIN[Q_BIT-1:0];
        end else begin
            return v[Q_BIT-1:0];
        end
    endfunction

    assign load_ready = ena & ~pend_full_q;
    assign capture    = load_valid & load_ready;
    assign beat       = m_valid_q & m_ready;
    assign last_beat  = beat & (idx_q == IDX_LAST);

    always_comb begin
        state_d     = state_q;
        act_d       = act_q;
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        idx_d       = idx_q;
        col_d       = col_q;

        case (state_q)
            S_IDLE: begin
                if (capture) begin
                    act_d   = data_in;
                    idx_d   = '0;
                    col_d   = '0;
                    state_d = S_STREAM;
                end
            end
            S_STREAM: begin
                if (last_beat) begin
                    idx_d = '0;
                    col_d = '0;
                    // A full pending slot forces load_ready low this cycle,
                    // so at most one of these two refill paths can be taken.
                    if (pend_full_q) begin
                        act_d       = pend_q;
                        pend_full_d = 1'b0;
                    end else if (capture) begin
                        act_d = data_in;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    if (beat) begin
                        idx_d = idx_q + IDX_W'(1);
                        col_d = (col_q == COL_LAST) ? '0 : col_q + COL_W'(1);
                    end
                    if (capture) begin
                        pend_d      = data_in;
                        pend_full_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // The outputs are computed from the next-state view so that they are
    // registered. They still show the element selected by idx_d in the same
    // cycle that it becomes current. A stalled word therefore stays stable,
    // because act_d and idx_d do not move.
    assign elem_sel = act_d[int'(idx_d) * OUT_BIT +: OUT_BIT];

    always_comb begin
        m_valid_d    = (state_d == S_STREAM);
        m_data_d     = '0;
        m_last_row_d = 1'b0;
        m_last_d     = 1'b0;
        if (state_d == S_STREAM) begin
            m_data_d     = quantize(elem_sel);
            m_last_row_d = (col_d == COL_LAST);
            m_last_d     = (idx_d == IDX_LAST);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            pend_full_q  <= 1'b0;
            idx_q        <= '0;
            col_q        <= '0;
            m_valid_q    <= 1'b0;
            m_data_q     <= '0;
            m_last_row_q <= 1'b0;
            m_last_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            pend_full_q  <= pend_full_d;
            idx_q        <= idx_d;
            col_q        <= col_d;
            m_valid_q    <= m_valid_d;
            m_data_q     <= m_data_d;
            m_last_row_q <= m_last_row_d;
            m_last_q     <= m_last_d;
        end
    end

    // Mesh storage is qualified by state_q/pend_full_q, so it needs no reset.
    // Clearing those two flags already discards the contents.
    always_ff @(posedge clk) begin
        act_q  <= act_d;
        pend_q <= pend_d;
    end

    assign m_valid    = m_valid_q;
    assign m_data     = m_data_q;
    assign m_last_row = m_last_row_q;
    assign m_last     = m_last_q;
    assign busy       = (state_q == S_STREAM) | pend_full_q;

endmodule

// File: tb/tb_mesh_unloader.sv
// Testbench for mesh_unloader. The reference model is a queue of the words the
// stream still owes. Each accepted mesh appends its N quantised words, and each
// beat removes one. Every control output is derived from the queue depth: the
// pending slot is full exactly when more than one mesh worth of words is owed.
module tb_mesh_unloader;

    localparam int OUT_BIT = 32;
    localparam int MX      = 8;
    localparam int MY      = 8;
    localparam int QB      = 16;
    localparam int N       = MX * MY;
    localparam int MW      = N * OUT_BIT;

    typedef struct packed {
        logic [QB-1:0] d;
        logic          lr;
        logic          l;
    } word_t;

    logic          clk = 1'b0;
    logic          rst, ena, load_valid, m_ready;
    logic [MW-1:0] data_in;
    logic          load_ready, m_valid, m_last_row, m_last, busy;
    logic [QB-1:0] m_data;

    logic          load_valid2, m_ready2;
    logic [MW-1:0] data_in2;
    logic          load_ready2, m_valid2, m_last_row2, m_last2, busy2;
    logic [QB-1:0] m_data2;

    int    vectors = 0;
    int    miscompares = 0;
    word_t exp_q[$];
    bit    last_cap;

    always #5 clk = ~clk;

    mesh_unloader #(.OUT_BIT(OUT_BIT), .MESH_X(MX), .MESH_Y(MY), .Q_BIT(QB), .SHIFT(0)) u_dut (
        .clk(clk), .rst(rst), .ena(ena), .load_valid(load_valid), .load_ready(load_ready),
        .data_in(data_in), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_last_row(m_last_row), .m_last(m_last), .busy(busy));

    mesh_unloader #(.OUT_BIT(OUT_BIT), .MESH_X(MX), .MESH_Y(MY), .Q_BIT(QB), .SHIFT(4)) u_sat (
        .clk(clk), .rst(rst), .ena(ena), .load_valid(load_valid2), .load_ready(load_ready2),
        .data_in(data_in2), .m_valid(m_valid2), .m_ready(m_ready2), .m_data(m_data2),
        .m_last_row(m_last_row2), .m_last(m_last2), .busy(busy2));

    // Real-valued shift and clamp, done on a 64-bit integer.
    function automatic logic [QB-1:0] ref_q(input logic [31:0] e, input int sh);
        longint v;
        v = longint'($signed(e));
        v = v >>> sh;
        if (v > longint'(32767)) v = 32767;
        else if (v < -longint'(32768)) v = -32768;
        return v[QB-1:0];
    endfunction

    function automatic logic [31:0] rnd_elem();
        int s;
        case ($urandom_range(0, 3))
            0: return $urandom;
            1: begin s = int'($urandom_range(0, 80000)) - 40000; return 32'(s); end
            2: return ($urandom_range(0, 1) != 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
            default: begin
                s = int'($urandom_range(0, 6)) - 3;
                s = ($urandom_range(0, 1) != 0) ? 32767 + s : -32768 + s;
                return 32'(s);
            end
        endcase
    endfunction

    function automatic logic [MW-1:0] rnd_mesh();
        logic [MW-1:0] m;
        for (int i = 0; i < N; i++) m[i*32 +: 32] = rnd_elem();
        return m;
    endfunction

    function automatic logic [MW-1:0] const_mesh(input logic [31:0] v);
        logic [MW-1:0] m;
        for (int i = 0; i < N; i++) m[i*32 +: 32] = v;
        return m;
    endfunction

    task automatic push_mesh(input logic [MW-1:0] m);
        word_t w;
        for (int i = 0; i < N; i++) begin
            w.d  = ref_q(m[i*32 +: 32], 0);
            w.lr = ((i % MX) == MX - 1);
            w.l  = (i == N - 1);
            exp_q.push_back(w);
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle: check the current outputs against the model, take the edge,
    // and update the model the way the edge should have.
    task automatic step();
        bit exp_ready, exp_valid, beat, cap;
        #1;
        exp_valid = (exp_q.size() > 0);
        exp_ready = ena && (exp_q.size() <= N);
        chk("load_ready", 32'(load_ready), 32'(exp_ready));
        chk("m_valid", 32'(m_valid), 32'(exp_valid));
        chk("busy", 32'(busy), 32'(exp_valid));
        if (exp_valid) begin
            chk("m_data", 32'(m_data), 32'(exp_q[0].d));
            chk("m_last_row", 32'(m_last_row), 32'(exp_q[0].lr));
            chk("m_last", 32'(m_last), 32'(exp_q[0].l));
        end
        beat = exp_valid && m_ready;
        cap  = load_valid && exp_ready;
        @(posedge clk);
        if (rst) begin
            exp_q.delete();
        end else begin
            if (beat) void'(exp_q.pop_front());
            if (cap) push_mesh(data_in);
        end
        last_cap = cap && !rst;
        #1;
    endtask

    task automatic drain(input string tag);
        load_valid = 1'b0;
        m_ready    = 1'b1;
        for (int c = 0; c < 3 * N && exp_q.size() > 0; c++) step();
        step();
        chk({tag, "_drained_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [MW-1:0] m;
        logic [31:0]   e;
        int            bp;

        rst = 1'b1; ena = 1'b0; load_valid = 1'b0; m_ready = 1'b0; data_in = '0;
        load_valid2 = 1'b0; m_ready2 = 1'b1; data_in2 = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_m_data", 32'(m_data), 32'd0);
        chk("rst_m_last_row", 32'(m_last_row), 32'd0);
        chk("rst_m_last", 32'(m_last), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_load_ready_ena0", 32'(load_ready), 32'd0);
        ena = 1'b1;
        #1;
        chk("rst_load_ready_ena1", 32'(load_ready), 32'd1);

        // Ramp mesh, continuous ready.
        for (int i = 0; i < N; i++) m[i*32 +: 32] = 32'(i);
        data_in = m; load_valid = 1'b1; m_ready = 1'b1;
        step();
        load_valid = 1'b0;
        drain("ramp");

        // Backpressure pattern 1,0,0,1.
        data_in = rnd_mesh(); load_valid = 1'b1;
        step();
        load_valid = 1'b0;
        bp = 0;
        for (int c = 0; c < 6 * N && exp_q.size() > 0; c++) begin
            m_ready = (bp == 0 || bp == 3);
            bp = (bp + 1) % 4;
            step();
        end
        chk("bp_drained_busy", 32'(busy), 32'd0);

        // Double buffering: A streaming, B pending, C waits for the slot.
        m_ready = 1'b1;
        data_in = const_mesh(32'd5); load_valid = 1'b1;
        step();
        load_valid = 1'b0;
        for (int c = 0; c < N && exp_q.size() > N - 10; c++) step();
        data_in = const_mesh(-32'sd3); load_valid = 1'b1;
        step();
        chk("dbl_b_accepted", 32'(last_cap), 32'd1);
        data_in = rnd_mesh();
        for (int c = 0; c < 3 * N; c++) begin
            step();
            if (last_cap) break;
        end
        chk("dbl_c_accepted", 32'(last_cap), 32'd1);
        load_valid = 1'b0;
        drain("dbl");

        // Capture in the same cycle as the last beat, pending slot empty.
        data_in = rnd_mesh(); load_valid = 1'b1;
        step();
        load_valid = 1'b0;
        for (int c = 0; c < 2 * N && exp_q.size() > 1; c++) step();
        data_in = rnd_mesh(); load_valid = 1'b1;
        step();
        load_valid = 1'b0;
        chk("same_cycle_busy", 32'(busy), 32'd1);
        chk("same_cycle_valid", 32'(m_valid), 32'd1);
        drain("same");

        // ena gating in IDLE, then reset in the middle of a stream.
        ena = 1'b0; data_in = rnd_mesh(); load_valid = 1'b1;
        repeat (3) step();
        ena = 1'b1;
        step();
        chk("ena_capture", 32'(last_cap), 32'd1);
        load_valid = 1'b0;
        for (int c = 0; c < N && exp_q.size() > N - 30; c++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_m_valid", 32'(m_valid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_m_data", 32'(m_data), 32'd0);
        chk("midrst_m_last", 32'(m_last), 32'd0);
        chk("midrst_m_last_row", 32'(m_last_row), 32'd0);
        repeat (3) step();
        data_in = rnd_mesh(); load_valid = 1'b1;
        step();
        load_valid = 1'b0;
        for (int c = 0; c < 200; c++) begin
            m_ready = ($urandom_range(0, 2) != 0);
            step();
        end
        drain("restart");

        // Random traffic.
        for (int c = 0; c < 1500; c++) begin
            ena        = ($urandom_range(0, 7) != 0);
            load_valid = ($urandom_range(0, 3) == 0);
            m_ready    = ($urandom_range(0, 2) != 0);
            rst        = ($urandom_range(0, 499) == 0);
            if (load_valid) data_in = rnd_mesh();
            step();
        end
        rst = 1'b0; ena = 1'b1;
        drain("random");

        // Saturation through the SHIFT=4 instance.
        m = rnd_mesh();
        m[0*32 +: 32] = 32'h7FFF_FFFF;
        m[1*32 +: 32] = 32'h8000_0000;
        m[2*32 +: 32] = 32'h0001_2340;
        m[3*32 +: 32] = 32'hFFFF_FFF0;
        data_in2 = m; load_valid2 = 1'b1;
        #1;
        chk("sat_load_ready", 32'(load_ready2), 32'd1);
        @(posedge clk);
        #1 load_valid2 = 1'b0;
        for (int k = 0; k < N; k++) begin
            e = m[k*32 +: 32];
            #1;
            chk("sat_m_valid", 32'(m_valid2), 32'd1);
            chk("sat_m_data", 32'(m_data2), 32'(ref_q(e, 4)));
            if (k == 0) chk("sat_pos_clip", 32'(m_data2), 32'h7FFF);
            if (k == 1) chk("sat_neg_clip", 32'(m_data2), 32'h8000);
            if (k == 2) chk("sat_in_range", 32'(m_data2), 32'h1234);
            if (k == 3) chk("sat_minus_one", 32'(m_data2), 32'hFFFF);
            chk("sat_m_last", 32'(m_last2), 32'(k == N - 1));
            chk("sat_m_last_row", 32'(m_last_row2), 32'((k % MX) == MX - 1));
            @(posedge clk);
        end
        #1;
        chk("sat_end_valid", 32'(m_valid2), 32'd0);
        chk("sat_end_busy", 32'(busy2), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
